key_word_loader: RTL

- Input-direction counterpart to the board's result/hex-display path. Turns raw board switches and pushbuttons into committed 16-bit data words for the 16-bit CPU.
- The operator enters a word byte-by-byte from SW[7:0] using a "load" button, then presses a "commit" button.
- The block then presents the word to the CPU over a valid/ready handshake.
- Includes per-button synchronisation, debounce and press-edge detection, plus a live preview word the top level can route to the hex display.

---
 rtl/cpu16_io_pkg.sv | 14 +
 rtl/key_debounce.sv | 46 ++++
 rtl/key_word_loader.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cpu16_io_pkg.sv
// Shared constants and loader state encoding for the 16-bit CPU board I/O path.
package cpu16_io_pkg;

    localparam int WORD_W = 16;
    localparam int SW_W   = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HAVE_LO   = 2'd1,
        HAVE_BOTH = 2'd2,
        PENDING   = 2'd3
    } loader_state_t;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a
// single-cycle pulse on each accepted press (high-to-low of the debounced level).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_prev;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            stable      <= 1'b1;
            stable_prev <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync1       <= key_n;
            sync2       <= sync1;
            stable_prev <= stable;
            press_pulse <= stable_prev & ~stable;
            // Any sample agreeing with the accepted level restarts the count.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_word_loader.sv
// Assembles a 16-bit word from switch bytes via load/commit buttons and hands
// it to the CPU over a registered valid/ready handshake.
module key_word_loader
    import cpu16_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load_n,
    input  logic              key_commit_n,
    input  logic [SW_W-1:0]   sw,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] preview,
    output logic [1:0]        fill_state,
    output logic              overrun
);

    logic load_p;
    logic commit_p;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_load_n),
        .press_pulse (load_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit_db (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_commit_n),
        .press_pulse (commit_p)
    );

    loader_state_t     state_q, state_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        hi_q, hi_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [WORD_W-1:0] preview_q, preview_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lo_q      <= '0;
            hi_q      <= '0;
            data_q    <= '0;
            preview_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            data_q    <= data_d;
            preview_q <= preview_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        // Commit is tested first everywhere so it wins over a coincident load.
        case (state_q)
            IDLE: begin
                if (commit_p) begin
                    data_d  = {{(WORD_W-SW_W){sw[SW_W-1]}}, sw};
                    state_d = PENDING;
                end else if (load_p) begin
                    lo_d    = sw[7:0];
                    hi_d    = '0;
                    state_d = HAVE_LO;
                end
            end
            HAVE_LO: begin
                if (commit_p) begin
                    data_d  = {{8{lo_q[7]}}, lo_q};
                    state_d = PENDING;
                end else if (load_p) begin
                    hi_d    = sw[7:0];
                    state_d = HAVE_BOTH;
                end
            end
            HAVE_BOTH: begin
                if (commit_p) begin
                    data_d  = {hi_q, lo_q};
                    state_d = PENDING;
                end else if (load_p) begin
                    lo_d    = sw[7:0];
                    hi_d    = '0;
                    state_d = HAVE_LO;
                end
            end
            PENDING: begin
                if (load_p || commit_p) begin
                    overrun_d = 1'b1;
                end
                if (out_ready) begin
                    lo_d    = '0;
                    hi_d    = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == PENDING);
        case (state_d)
            HAVE_LO, HAVE_BOTH: preview_d = {hi_d, lo_d};
            PENDING:            preview_d = data_d;
            default:            preview_d = '0;
        endcase
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign preview    = preview_q;
    assign fill_state = state_q;
    assign overrun    = overrun_q;

endmodule
